// File: rtl/reg_wr_arb_pkg.sv
// Shared definitions for the register-file write-port arbiter: default sizes,
// the per-requester write record and the round-robin pointer increment.
package reg_wr_arb_pkg;

  localparam int unsigned DefW    = 8;
  localparam int unsigned DefA    = 2;
  localparam int unsigned DefNreq = 3;

  // Widest supported data path and address; narrower builds zero-extend.
  localparam int unsigned MaxW = 8;
  localparam int unsigned MaxA = 2;

  typedef struct packed {
    logic [MaxA-1:0] addr;
    logic [MaxW-1:0] data;
  } wr_req_t;

  // Modulo-n increment used to move the round-robin pointer past a winner.
  function automatic int unsigned next_ptr(input int unsigned idx, input int unsigned n);
    return ((idx + 1) >= n) ? 0 : (idx + 1);
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational rotate-search: first set request at or after ptr_i, wrapping
// modulo N. Shared by the arbiters of other single-port resources.
module rr_pick #(
  parameter int unsigned N  = 3,
  parameter int unsigned IW = 2
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] idx_o,
  output logic          any_o
);

  int unsigned j;

  // Walk the request vector starting at the pointer; first hit wins.
  always_comb begin
    j     = 0;
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    for (int unsigned k = 0; k < N; k++) begin
      j = 32'(ptr_i) + k;
      if (j >= N) j = j - N;
      if (!any_o && req_i[j]) begin
        any_o    = 1'b1;
        gnt_o[j] = 1'b1;
        idx_o    = IW'(j);
      end
    end
  end

endmodule

// File: rtl/reg_wr_arbiter.sv
// Round-robin arbiter sharing the single register-file write port between NREQ
// writers. The winner is registered into one output stage (latency 1), which
// is also exported as the pending write for decode bypass / RAW stall.
// Optional build macro REG_WR_ARB_PRIO0_EN: requester 0 gets absolute priority
// and does not move the pointer; the others rotate among themselves.
module reg_wr_arbiter
  import reg_wr_arb_pkg::*;
#(
  parameter int unsigned W    = DefW,
  parameter int unsigned A    = DefA,
  parameter int unsigned NREQ = DefNreq,
  localparam int unsigned IW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic [NREQ-1:0]   ReqValid,
  input  logic [NREQ*A-1:0] ReqAddr,
  input  logic [NREQ*W-1:0] ReqData,
  output logic [NREQ-1:0]   ReqReady,
  input  logic              Hold,
  output logic              WriteEn,
  output logic [A-1:0]      Waddr,
  output logic [W-1:0]      DataIn,
  output logic              PendValid,
  output logic [A-1:0]      PendAddr,
  output logic [W-1:0]      PendData,
  output logic [IW-1:0]     GrantIdx
);

  logic          we_q, we_d;
  logic [A-1:0]  addr_q, addr_d;
  logic [W-1:0]  data_q, data_d;
  logic [IW-1:0] gidx_q, gidx_d;
  logic [IW-1:0] ptr_q, ptr_d;

  wr_req_t       req_s [NREQ];
  wr_req_t       win_s;
  logic [NREQ-1:0] rr_req, rr_gnt, gnt;
  logic [IW-1:0] rr_idx, win_idx;
  logic          rr_any, win_any, prio_win;

  // Unpack the flat request buses into per-requester records.
  always_comb begin
    for (int unsigned i = 0; i < NREQ; i++) begin
      req_s[i].addr = MaxA'(ReqAddr[i*A +: A]);
      req_s[i].data = MaxW'(ReqData[i*W +: W]);
    end
  end

`ifdef REG_WR_ARB_PRIO0_EN
  // Requester 0 is served outside the rotation.
  always_comb begin
    rr_req    = ReqValid;
    rr_req[0] = 1'b0;
  end
`else
  assign rr_req = ReqValid;
`endif

  rr_pick #(
    .N  (NREQ),
    .IW (IW)
  ) u_rr_pick (
    .req_i (rr_req),
    .ptr_i (ptr_q),
    .gnt_o (rr_gnt),
    .idx_o (rr_idx),
    .any_o (rr_any)
  );

  // Grant decision; nothing is accepted under Hold or while in reset.
  always_comb begin
    gnt      = '0;
    win_idx  = '0;
    win_any  = 1'b0;
    prio_win = 1'b0;
    if (!Hold && !Reset) begin
`ifdef REG_WR_ARB_PRIO0_EN
      if (ReqValid[0]) begin
        gnt[0]   = 1'b1;
        win_any  = 1'b1;
        prio_win = 1'b1;
      end else begin
        gnt     = rr_gnt;
        win_idx = rr_idx;
        win_any = rr_any;
      end
`else
      gnt     = rr_gnt;
      win_idx = rr_idx;
      win_any = rr_any;
`endif
    end
  end

  assign ReqReady = gnt;
  assign win_s    = req_s[win_idx];

  // Next state of the output stage and the round-robin pointer.
  always_comb begin
    we_d   = win_any;
    addr_d = addr_q;
    data_d = data_q;
    gidx_d = gidx_q;
    ptr_d  = ptr_q;
    if (win_any) begin
      addr_d = win_s.addr[A-1:0];
      data_d = win_s.data[W-1:0];
      gidx_d = win_idx;
      if (!prio_win) ptr_d = IW'(next_ptr(32'(win_idx), NREQ));
    end
  end

  // Output stage and pointer; reset drops any write still in the stage.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      we_q   <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
      gidx_q <= '0;
      ptr_q  <= '0;
    end else begin
      we_q   <= we_d;
      addr_q <= addr_d;
      data_q <= data_d;
      gidx_q <= gidx_d;
      ptr_q  <= ptr_d;
    end
  end

  assign WriteEn   = we_q;
  assign Waddr     = addr_q;
  assign DataIn    = data_q;
  assign PendValid = we_q;
  assign PendAddr  = addr_q;
  assign PendData  = data_q;
  assign GrantIdx  = gidx_q;

endmodule
